// File: rtl/muldiv_seq.sv
// muldiv_seq: execute-stage multiply/divide sequencer.
// Owns HI/LO and computes 32x32 products in one cycle.
// Runs the valid/ready handshake of the signed and unsigned divider cores.
// Stalls the pipeline while an operation is in flight.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        divs_tvalid,
  input  logic        divs_tready,
  input  logic        divs_dout_tvalid,
  input  logic [63:0] divs_dout_tdata,
  output logic        divu_tvalid,
  input  logic        divu_tready,
  input  logic        divu_dout_tvalid,
  input  logic [63:0] divu_dout_tdata
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DREQ  = 3'd2,
    ST_DWAIT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] src1_q, src2_q;
  logic [31:0] hi_q, lo_q;
  logic        drain_q, drain_sel_q;

  logic        req_mul, req_div, accept;
  logic        op_is_divu;
  logic        sel_tready, sel_dout_tvalid, drain_dout;
  logic [63:0] sel_dout_tdata;
  logic        sx1, sx2;
  logic [63:0] mul_a, mul_b, mul_p;

  assign req_mul = req_valid && !flush && (req_op == OP_MULT || req_op == OP_MULTU);
  assign req_div = req_valid && !flush && (req_op == OP_DIV  || req_op == OP_DIVU);
  // A divide must wait for a cancelled division's result to drain out of the cores;
  // multiplies do not touch the dividers and go ahead regardless.
  assign accept  = (state_q == ST_IDLE) && (req_mul || (req_div && !drain_q));

  assign op_is_divu      = (op_q == OP_DIVU);
  assign sel_tready      = op_is_divu ? divu_tready      : divs_tready;
  assign sel_dout_tvalid = op_is_divu ? divu_dout_tvalid : divs_dout_tvalid;
  assign sel_dout_tdata  = op_is_divu ? divu_dout_tdata  : divs_dout_tdata;
  assign drain_dout      = drain_sel_q ? divu_dout_tvalid : divs_dout_tvalid;

  // Low 64 bits of the product of 33-bit extended operands equal the low 64 bits
  // of the product of the operands extended to 64 bits.
  assign sx1   = (op_q == OP_MULT) && src1_q[31];
  assign sx2   = (op_q == OP_MULT) && src2_q[31];
  assign mul_a = {{32{sx1}}, src1_q};
  assign mul_b = {{32{sx2}}, src2_q};
  assign mul_p = mul_a * mul_b;

  assign hi           = hi_q;
  assign lo           = lo_q;
  assign div_dividend = src1_q;
  assign div_divisor  = src2_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = req_mul ? ST_MUL : ST_DREQ;
      ST_MUL:   state_d = flush ? ST_IDLE : ST_DONE;
      ST_DREQ:  if (flush) state_d = ST_IDLE;
                else if (sel_tready) state_d = ST_DWAIT;
      ST_DWAIT: if (flush) state_d = ST_IDLE;
                else if (sel_dout_tvalid) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; tvalid depends on registered state only
  always_comb begin
    stall       = 1'b0;
    done        = 1'b0;
    divs_tvalid = 1'b0;
    divu_tvalid = 1'b0;
    case (state_q)
      ST_IDLE:  stall = req_mul || req_div;
      ST_MUL:   stall = 1'b1;
      ST_DREQ:  begin
        stall       = 1'b1;
        divs_tvalid = !op_is_divu;
        divu_tvalid = op_is_divu;
      end
      ST_DWAIT: stall = 1'b1;
      ST_DONE:  done  = 1'b1;
      default:  ;
    endcase
  end

  // Operand capture, HI/LO writes and drain tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= 3'd0;
      src1_q      <= 32'd0;
      src2_q      <= 32'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      drain_q     <= 1'b0;
      drain_sel_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= req_op;
        src1_q <= req_src1;
        src2_q <= req_src2;
      end
      if (state_q == ST_IDLE && req_valid && !flush) begin
        if (req_op == OP_MTHI) hi_q <= req_src1;
        if (req_op == OP_MTLO) lo_q <= req_src1;
      end
      if (state_q == ST_MUL && !flush) begin
        hi_q <= mul_p[63:32];
        lo_q <= mul_p[31:0];
      end
      if (state_q == ST_DWAIT && !flush && sel_dout_tvalid) begin
        lo_q <= sel_dout_tdata[63:32];
        hi_q <= sel_dout_tdata[31:0];
      end
      if (drain_q && drain_dout) drain_q <= 1'b0;
      // A cancelled division whose request was taken still owes a result. If that
      // result arrives in the flush cycle itself, nothing is left to drain.
      if (flush && ((state_q == ST_DWAIT && !sel_dout_tvalid) ||
                    (state_q == ST_DREQ && sel_tready))) begin
        drain_q     <= 1'b1;
        drain_sel_q <= op_is_divu;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed tests for muldiv_seq with behavioural divider cores.
module tb_muldiv_seq;

  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        flush;
  logic        stall, done;
  logic [31:0] hi, lo, div_dividend, div_divisor;
  logic        divs_tvalid, divs_tready, divs_dout_tvalid;
  logic [63:0] divs_dout_tdata;
  logic        divu_tvalid, divu_tready, divu_dout_tvalid;
  logic [63:0] divu_dout_tdata;

  int n_checks = 0;
  int n_pass   = 0;
  int ready_delay = 0;

  // results collected by run_op
  int   r_stalls, r_dones, r_stv, r_utv;
  logic r_hl_early;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .flush(flush), .stall(stall), .done(done), .hi(hi), .lo(lo),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .divs_tvalid(divs_tvalid), .divs_tready(divs_tready),
    .divs_dout_tvalid(divs_dout_tvalid), .divs_dout_tdata(divs_dout_tdata),
    .divu_tvalid(divu_tvalid), .divu_tready(divu_tready),
    .divu_dout_tvalid(divu_dout_tvalid), .divu_dout_tdata(divu_dout_tdata)
  );

  // ---------------- divider core models ----------------
  logic [31:0] s_q, s_r, u_q, u_r;
  always_comb begin
    s_q = 32'hFFFFFFFF; s_r = div_dividend;
    u_q = 32'hFFFFFFFF; u_r = div_dividend;
    if (div_divisor != 32'd0) begin
      s_q = $signed(div_dividend) / $signed(div_divisor);
      s_r = $signed(div_dividend) % $signed(div_divisor);
      u_q = div_dividend / div_divisor;
      u_r = div_dividend % div_divisor;
    end
  end

  logic        s_busy, u_busy;
  int          s_cnt, s_wait, u_cnt, u_wait;
  logic [63:0] s_data, u_data;

  assign divs_tready      = divs_tvalid && !s_busy && (s_wait >= ready_delay);
  assign divs_dout_tvalid = s_busy && (s_cnt == DIV_LAT);
  assign divs_dout_tdata  = s_data;
  assign divu_tready      = divu_tvalid && !u_busy && (u_wait >= ready_delay);
  assign divu_dout_tvalid = u_busy && (u_cnt == DIV_LAT);
  assign divu_dout_tdata  = u_data;

  always @(posedge clk) begin
    if (reset) begin
      s_busy <= 1'b0; s_cnt <= 0; s_wait <= 0; s_data <= 64'd0;
    end else if (divs_tvalid && divs_tready) begin
      s_busy <= 1'b1; s_cnt <= 1; s_wait <= 0; s_data <= {s_q, s_r};
    end else begin
      s_wait <= divs_tvalid ? s_wait + 1 : 0;
      if (s_busy) begin
        if (s_cnt == DIV_LAT) s_busy <= 1'b0;
        else s_cnt <= s_cnt + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      u_busy <= 1'b0; u_cnt <= 0; u_wait <= 0; u_data <= 64'd0;
    end else if (divu_tvalid && divu_tready) begin
      u_busy <= 1'b1; u_cnt <= 1; u_wait <= 0; u_data <= {u_q, u_r};
    end else begin
      u_wait <= divu_tvalid ? u_wait + 1 : 0;
      if (u_busy) begin
        if (u_cnt == DIV_LAT) u_busy <= 1'b0;
        else u_cnt <= u_cnt + 1;
      end
    end
  end

  // Present one request, hold it while stalled, and collect what was observed.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] hl0;
    r_stalls = 0; r_dones = 0; r_stv = 0; r_utv = 0; r_hl_early = 1'b0;
    hl0 = {hi, lo};
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (stall) r_stalls++;
      if (done) r_dones++;
      if (divs_tvalid) r_stv++;
      if (divu_tvalid) r_utv++;
      if (!done && {hi, lo} !== hl0) r_hl_early = 1'b1;
      if (!stall) break;
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0; req_op = 3'd0;
    #1;
    if (done) r_dones++;
    $display("op=%0d a=%h b=%h stalls=%0d dones=%0d hi=%h lo=%h",
             op, a, b, r_stalls, r_dones, hi, lo);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_src1 = 32'd0; req_src2 = 32'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_checks++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo got %h exp 0", {hi, lo}); else n_pass++;
    n_checks++; if ({divs_tvalid, divu_tvalid} !== 2'b00)
      $display("FAIL reset_tvalid got %b exp 00", {divs_tvalid, divu_tvalid}); else n_pass++;
    reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_mult();
    run_op(3'd1, 32'hFFFFFFFD, 32'd5);
    n_checks++; if (r_stalls !== 2) $display("FAIL mult_stall got %0d exp 2", r_stalls); else n_pass++;
    n_checks++; if (r_dones !== 1) $display("FAIL mult_done got %0d exp 1", r_dones); else n_pass++;
    n_checks++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi got %h exp FFFFFFFF", hi); else n_pass++;
    n_checks++; if (lo !== 32'hFFFFFFF1) $display("FAIL mult_lo got %h exp FFFFFFF1", lo); else n_pass++;
    n_checks++; if (r_hl_early !== 1'b0) $display("FAIL mult_early got %b exp 0", r_hl_early); else n_pass++;
  endtask

  task automatic test_multu_mtlo();
    run_op(3'd2, 32'hFFFFFFFF, 32'd2);
    n_checks++; if (r_stalls !== 2) $display("FAIL multu_stall got %0d exp 2", r_stalls); else n_pass++;
    n_checks++; if (hi !== 32'h00000001) $display("FAIL multu_hi got %h exp 00000001", hi); else n_pass++;
    n_checks++; if (lo !== 32'hFFFFFFFE) $display("FAIL multu_lo got %h exp FFFFFFFE", lo); else n_pass++;
    run_op(3'd6, 32'h00001234, 32'd0);
    n_checks++; if (r_stalls !== 0) $display("FAIL mtlo_stall got %0d exp 0", r_stalls); else n_pass++;
    n_checks++; if (lo !== 32'h00001234) $display("FAIL mtlo_lo got %h exp 00001234", lo); else n_pass++;
    n_checks++; if (hi !== 32'h00000001) $display("FAIL mtlo_hi got %h exp 00000001", hi); else n_pass++;
    n_checks++; if (r_dones !== 0) $display("FAIL mtlo_done got %0d exp 0", r_dones); else n_pass++;
    run_op(3'd5, 32'hCAFE0000, 32'd0);
    n_checks++; if (hi !== 32'hCAFE0000) $display("FAIL mthi_hi got %h exp CAFE0000", hi); else n_pass++;
  endtask

  task automatic test_unused_op();
    run_op(3'd7, 32'h11111111, 32'h22222222);
    n_checks++; if (r_stalls !== 0) $display("FAIL unused_stall got %0d exp 0", r_stalls); else n_pass++;
    n_checks++; if ({hi, lo} !== 64'hCAFE0000_00001234)
      $display("FAIL unused_hilo got %h exp CAFE000000001234", {hi, lo}); else n_pass++;
  endtask

  task automatic test_div();
    ready_delay = 2;
    run_op(3'd3, 32'hFFFFFFF9, 32'd2);
    n_checks++; if (r_stalls !== 12) $display("FAIL div_stall got %0d exp 12", r_stalls); else n_pass++;
    n_checks++; if (r_stv !== 3) $display("FAIL div_tvalid_cycles got %0d exp 3", r_stv); else n_pass++;
    n_checks++; if (r_utv !== 0) $display("FAIL div_divu_tvalid got %0d exp 0", r_utv); else n_pass++;
    n_checks++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo got %h exp FFFFFFFD", lo); else n_pass++;
    n_checks++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi got %h exp FFFFFFFF", hi); else n_pass++;
    n_checks++; if (r_dones !== 1) $display("FAIL div_done got %0d exp 1", r_dones); else n_pass++;
    n_checks++; if (r_hl_early !== 1'b0) $display("FAIL div_early got %b exp 0", r_hl_early); else n_pass++;
  endtask

  task automatic test_divu();
    ready_delay = 0;
    run_op(3'd4, 32'h80000000, 32'd3);
    n_checks++; if (r_stalls !== 10) $display("FAIL divu_stall got %0d exp 10", r_stalls); else n_pass++;
    n_checks++; if (r_stv !== 0) $display("FAIL divu_divs_tvalid got %0d exp 0", r_stv); else n_pass++;
    n_checks++; if (lo !== 32'h2AAAAAAA) $display("FAIL divu_lo got %h exp 2AAAAAAA", lo); else n_pass++;
    n_checks++; if (hi !== 32'h00000002) $display("FAIL divu_hi got %h exp 00000002", hi); else n_pass++;
  endtask

  task automatic test_flush_drain();
    ready_delay = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; req_src1 = 32'd100; req_src2 = 32'd7;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL flush_accept_stall got %b exp 1", stall); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (divs_tvalid !== 1'b1) $display("FAIL flush_dreq_tvalid got %b exp 1", divs_tvalid); else n_pass++;
    @(negedge clk);
    flush = 1'b1;
    #1;
    n_checks++; if (divs_tvalid !== 1'b0) $display("FAIL flush_dwait_tvalid got %b exp 0", divs_tvalid); else n_pass++;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0; req_op = 3'd0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL flush_idle_stall got %b exp 0", stall); else n_pass++;
    $display("DIV flushed in DWAIT");
    run_op(3'd4, 32'd10, 32'd3);
    n_checks++; if (r_stalls !== 16) $display("FAIL drain_stall got %0d exp 16", r_stalls); else n_pass++;
    n_checks++; if (r_hl_early !== 1'b0) $display("FAIL drain_hilo_early got %b exp 0", r_hl_early); else n_pass++;
    n_checks++; if (r_stv !== 0) $display("FAIL drain_divs_tvalid got %0d exp 0", r_stv); else n_pass++;
    n_checks++; if (r_utv !== 1) $display("FAIL drain_divu_tvalid got %0d exp 1", r_utv); else n_pass++;
    n_checks++; if ({hi, lo} !== {32'd1, 32'd3})
      $display("FAIL drain_result got %h exp 0000000100000003", {hi, lo}); else n_pass++;
  endtask

  task automatic test_reset_mid_div();
    ready_delay = 5;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd3; req_src1 = 32'd50; req_src2 = 32'd5;
    @(negedge clk); #1;
    n_checks++; if (divs_tvalid !== 1'b1) $display("FAIL rmid_dreq_tvalid got %b exp 1", divs_tvalid); else n_pass++;
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0;
    @(negedge clk); #1;
    n_checks++; if ({stall, done, divs_tvalid, divu_tvalid} !== 4'b0000)
      $display("FAIL rmid_ctrl got %b exp 0000", {stall, done, divs_tvalid, divu_tvalid}); else n_pass++;
    n_checks++; if ({hi, lo} !== 64'd0) $display("FAIL rmid_hilo got %h exp 0", {hi, lo}); else n_pass++;
    n_checks++; if ({div_dividend, div_divisor} !== 64'd0)
      $display("FAIL rmid_operands got %h exp 0", {div_dividend, div_divisor}); else n_pass++;
    reset = 1'b0;
    $display("reset during DREQ");
    ready_delay = 0;
    run_op(3'd1, 32'd6, 32'd7);
    n_checks++; if (lo !== 32'd42) $display("FAIL rmid_after_mult got %h exp 0000002a", lo); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_mtlo();
    test_unused_op();
    test_div();
    test_divu();
    test_flush_drain();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
